data_memory_responder: RTL
==========================

// Module: data_memory_responder
// PURPOSE
//  Data-memory end of the CU<->DM memory interface: receives cmd/addr from the
//  interface block and serves 8-bit reads/writes on the shared data_dm bus.
//  Holds a 2^ADDR_W x DATA_W RAM behind a req/ack handshake with programmable
//  wait states. Sits between the memory interface and any slower memory model.
// PARAMETERS
//  DATA_W       8   data word width
//  ADDR_W       8   address width; depth = 2^ADDR_W, every address valid
//  WAIT_CYCLES  1   wait states between accept and array access (0..15)
// PORTS
//  clk      in     1       single clock, all state on rising edge
//  rst      in     1       synchronous active-high reset
//  req      in     1       access request, level, sampled in IDLE only
//  cmd      in     1       0 = read, 1 = write (same encoding as interface cmd_out)
//  addr     in     ADDR_W  word address (interface addr_out)
//  data_dm  inout  DATA_W  driven by this block when cmd==0, else high-Z
//  ack      out    1       one-cycle pulse: access complete / read data valid
//  busy     out    1       1 from accept until the ACK cycle ends
//  par_err  out    1       parity error on last read (0 unless DM_PARITY_EN)
// BEHAVIOUR
//  - Reset: state=IDLE, ack=0, busy=0, rd_q=0, wait counter=0, par_err=0.
//    RAM contents not reset. Reset in any state aborts; uncommitted write lost.
//  - FSM IDLE -> WAIT -> ACCESS -> ACK -> IDLE.
//    IDLE: req=1 at edge => latch cmd, addr and (if cmd=1) data_dm into wr_q;
//      cnt<=WAIT_CYCLES; go WAIT (ACCESS directly if WAIT_CYCLES==0); busy<=1.
//    WAIT: cnt decrements each cycle; leave for ACCESS when cnt==1, so exactly
//      WAIT_CYCLES cycles spent in WAIT.
//    ACCESS (1 cycle): write => mem[addr_q]<=wr_q; read => rd_q<=mem[addr_q].
//    ACK (1 cycle): ack=1, busy=1; next edge -> IDLE, busy<=0.
//  - Latency: accept edge N; ack high during cycle after edge N+1+WAIT_CYCLES.
//  - data_dm = (cmd==0) ? rd_q : 'z, using live cmd input (mirrors the
//    interface, which releases the bus on reads). rd_q holds last read data
//    until the next read's ACCESS, so the bus never floats during reads.
//  - Write data must be stable on data_dm at the accept edge; later changes
//    are ignored. cmd/addr changes after accept are ignored.
//  - req while busy (WAIT/ACCESS/ACK) ignored, not queued. req still high in
//    IDLE after ACK => new access accepted (back-to-back, one IDLE cycle).
//  - Address wrap: none; 8'hFF and 8'h00 are distinct locations.
// CONFIGURATION
//  DM_PARITY_EN defined: RAM widened by 1 bit; even parity of wr_q stored on
//    write. In ACCESS of a read, parity recomputed; par_err<=1 on mismatch,
//    valid with ack, held until next accepted request (cleared at accept).
//  DM_PARITY_EN undefined: no parity storage, par_err tied 0.
// TESTING
//  1 rst=1 two cycles, cmd=0 -> ack=0, busy=0, data_dm=8'h00, par_err=0.
//  2 WAIT_CYCLES=1: write 8'hA5 @8'h10, then read @8'h10 -> ack 3 cycles after
//    accept, ack width 1 cycle, data_dm=8'hA5 in ACK cycle and held after.
//  3 write 8'h11<-8'h3C, then req write 8'h11<-8'hFF while busy -> read
//    8'h11 returns 8'h3C; only one ack pulse for the pair.
//  4 write 8'hFF<-8'h01 and 8'h00<-8'h02 -> reads return 8'h01 and 8'h02.
//  5 write 8'h20<-8'h77 (prior 8'h55), rst=1 in WAIT -> busy=0 next cycle,
//    read 8'h20 returns 8'h55.
//  6 DM_PARITY_EN: write 8'h30<-8'h0F, flip stored parity via hierarchy,
//    read 8'h30 -> par_err=1 with ack; next clean read clears it to 0.

Source files
------------

// File: rtl/data_memory_responder.sv
// Data-memory responder: serves single-word reads/writes from the CU<->DM
// memory interface over the shared data_dm bus, behind a req/ack handshake
// with WAIT_CYCLES programmable wait states.
// Optional feature macro: DM_PARITY_EN (stores an even-parity bit per word and
// flags mismatches on reads through par_err).
module data_memory_responder #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              cmd,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data_dm,
  output logic              ack,
  output logic              busy,
  output logic              par_err
);

`ifdef DM_PARITY_EN
  localparam int unsigned MemW = DATA_W + 1;
`else
  localparam int unsigned MemW = DATA_W;
`endif
  localparam int unsigned Depth  = 2 ** ADDR_W;
  localparam bit          NoWait = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StAck} state_e;

  state_e              state_q, state_d;
  logic                cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wr_q, wr_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                par_err_q, par_err_d;

  logic [MemW-1:0]     mem [Depth];
  logic                mem_we;
  logic [MemW-1:0]     mem_wdata;
  logic [MemW-1:0]     mem_rdata;

  assign mem_rdata = mem[addr_q];

`ifdef DM_PARITY_EN
  // Even parity: stored bit makes the XOR of the whole stored word zero.
  assign mem_wdata = {^wr_q, wr_q};
`else
  assign mem_wdata = wr_q;
`endif

  // Next-state and handshake decode for the IDLE->WAIT->ACCESS->ACK sequence.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
    par_err_d = par_err_q;
    mem_we    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          cmd_d     = cmd;
          addr_d    = addr;
          if (cmd) wr_d = data_dm;
          cnt_d     = 4'(WAIT_CYCLES);
          busy_d    = 1'b1;
          par_err_d = 1'b0;
          state_d   = NoWait ? StAccess : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StAccess;
      end
      StAccess: begin
        if (cmd_q) begin
          mem_we = 1'b1;
        end else begin
          rd_d = mem_rdata[DATA_W-1:0];
`ifdef DM_PARITY_EN
          par_err_d = ^mem_rdata;
`endif
        end
        ack_d   = 1'b1;
        state_d = StAck;
      end
      StAck: begin
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and datapath registers; reset aborts any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cmd_q     <= 1'b0;
      addr_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      par_err_q <= par_err_d;
    end
  end

  // RAM array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[addr_q] <= mem_wdata;
  end

  // Drive the bus on reads using the live cmd so it never floats mid-read.
  assign data_dm = (cmd == 1'b0) ? rd_q : {DATA_W{1'bz}};

  assign ack     = ack_q;
  assign busy    = busy_q;
  assign par_err = par_err_q;

endmodule
